// File: rtl/dram_ctrl.sv
// dram_ctrl: open-page single-port DRAM command sequencer.
// Splits a word address into row/col and issues PRE/ACT/RD/WR with programmable waits.
module dram_ctrl #(
   parameter int unsigned TRP  = 5,
   parameter int unsigned TRCD = 5,
   parameter int unsigned TWR  = 5
) (
   input  logic        dram_clk,
   input  logic        dram_rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [20:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_wstrb,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        DRAM_CSn,
   output logic        DRAM_RASn,
   output logic        DRAM_CASn,
   output logic [3:0]  DRAM_WEn,
   output logic [10:0] DRAM_A,
   output logic [31:0] DRAM_D,
   input  logic [31:0] DRAM_Q,
   input  logic        DRAM_VALID
);

   typedef enum logic [3:0] {
      S_IDLE, S_PRE, S_PRE_W, S_ACT, S_ACT_W,
      S_RD, S_RD_W, S_WR, S_WR_W
   } state_t;

   localparam logic [3:0] TRP_M1  = 4'(TRP - 1);
   localparam logic [3:0] TRCD_M1 = 4'(TRCD - 1);
   localparam logic [3:0] TWR_M1  = 4'(TWR - 1);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        row_open, row_open_n;
   logic [10:0] open_row, open_row_n;

   logic        lat_write, lat_write_n;
   logic [20:0] lat_addr, lat_addr_n;
   logic [31:0] lat_wdata, lat_wdata_n;
   logic [3:0]  lat_wstrb, lat_wstrb_n;

   logic        req_ready_n;
   logic        rsp_valid_n;
   logic [31:0] rsp_rdata_n;

   logic        ras_d, cas_d;
   logic [3:0]  we_d;
   logic [10:0] a_d;
   logic [31:0] d_d;

   logic        accept;
   logic        hit;

   assign accept = (state == S_IDLE) && req_ready && req_valid;
   assign hit    = row_open && (req_addr[20:10] == open_row);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      row_open_n  = row_open;
      open_row_n  = open_row;
      lat_write_n = lat_write;
      lat_addr_n  = lat_addr;
      lat_wdata_n = lat_wdata;
      lat_wstrb_n = lat_wstrb;
      rsp_valid_n = 1'b0;
      rsp_rdata_n = rsp_rdata;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               lat_write_n = req_write;
               lat_addr_n  = req_addr;
               lat_wdata_n = req_wdata;
               lat_wstrb_n = req_wstrb;
               if (hit)
                  state_n = req_write ? S_WR : S_RD;
               else if (row_open)
                  state_n = S_PRE;
               else
                  state_n = S_ACT;
            end
         end
         S_PRE: begin
            state_n    = S_PRE_W;
            cnt_n      = TRP_M1;
            row_open_n = 1'b0;
         end
         S_PRE_W: begin
            if (cnt == 4'd0)
               state_n = S_ACT;
            else
               cnt_n = cnt - 4'd1;
         end
         S_ACT: begin
            state_n = S_ACT_W;
            cnt_n   = TRCD_M1;
         end
         S_ACT_W: begin
            if (cnt == 4'd0) begin
               row_open_n = 1'b1;
               open_row_n = lat_addr[20:10];
               state_n    = lat_write ? S_WR : S_RD;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         S_RD: state_n = S_RD_W;
         S_RD_W: begin
            if (DRAM_VALID) begin
               rsp_valid_n = 1'b1;
               rsp_rdata_n = DRAM_Q;
               state_n     = S_IDLE;
            end
         end
         S_WR: begin
            state_n = S_WR_W;
            cnt_n   = TWR_M1;
         end
         S_WR_W: begin
            if (cnt == 4'd0)
               state_n = S_IDLE;
            else
               cnt_n = cnt - 4'd1;
         end
         default: state_n = S_IDLE;
      endcase
      // write retires in the last wait cycle, which is the one entered with cnt 0
      if (state_n == S_WR_W && cnt_n == 4'd0)
         rsp_valid_n = 1'b1;
   end

   assign req_ready_n = (state_n == S_IDLE) && !rsp_valid_n;

   // pins are registered from the state being entered
   always_comb begin
      ras_d = 1'b1;
      cas_d = 1'b1;
      we_d  = 4'hF;
      a_d   = DRAM_A;
      d_d   = DRAM_D;
      case (state_n)
         S_PRE: begin
            ras_d = 1'b0;
            we_d  = 4'h0;
         end
         S_ACT: begin
            ras_d = 1'b0;
            a_d   = lat_addr_n[20:10];
         end
         S_RD: begin
            cas_d = 1'b0;
            a_d   = {1'b0, lat_addr_n[9:0]};
         end
         S_WR: begin
            cas_d = 1'b0;
            we_d  = ~lat_wstrb_n;
            a_d   = {1'b0, lat_addr_n[9:0]};
            d_d   = lat_wdata_n;
         end
         default: ;
      endcase
   end

   always_ff @(posedge dram_clk) begin
      if (!dram_rst_n) begin
         state     <= S_IDLE;
         cnt       <= 4'd0;
         row_open  <= 1'b0;
         open_row  <= 11'd0;
         lat_write <= 1'b0;
         lat_addr  <= 21'd0;
         lat_wdata <= 32'd0;
         lat_wstrb <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= 32'd0;
         DRAM_CSn  <= 1'b1;
         DRAM_RASn <= 1'b1;
         DRAM_CASn <= 1'b1;
         DRAM_WEn  <= 4'hF;
         DRAM_A    <= 11'd0;
         DRAM_D    <= 32'd0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         row_open  <= row_open_n;
         open_row  <= open_row_n;
         lat_write <= lat_write_n;
         lat_addr  <= lat_addr_n;
         lat_wdata <= lat_wdata_n;
         lat_wstrb <= lat_wstrb_n;
         req_ready <= req_ready_n;
         rsp_valid <= rsp_valid_n;
         rsp_rdata <= rsp_rdata_n;
         DRAM_CSn  <= 1'b0;
         DRAM_RASn <= ras_d;
         DRAM_CASn <= cas_d;
         DRAM_WEn  <= we_d;
         DRAM_A    <= a_d;
         DRAM_D    <= d_d;
      end
   end

endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: scoreboard bench for dram_ctrl with a small DRAM pin model.
// Expected commands/responses are queued by the stimulus and popped by the monitor.
module tb_dram_ctrl;

   localparam int TWR = 5;

   logic        dram_clk = 1'b0;
   logic        dram_rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [20:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        DRAM_CSn;
   logic        DRAM_RASn;
   logic        DRAM_CASn;
   logic [3:0]  DRAM_WEn;
   logic [10:0] DRAM_A;
   logic [31:0] DRAM_D;
   logic [31:0] DRAM_Q;
   logic        DRAM_VALID;

   dram_ctrl dut (
      .dram_clk   (dram_clk),
      .dram_rst_n (dram_rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_wstrb  (req_wstrb),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .DRAM_CSn   (DRAM_CSn),
      .DRAM_RASn  (DRAM_RASn),
      .DRAM_CASn  (DRAM_CASn),
      .DRAM_WEn   (DRAM_WEn),
      .DRAM_A     (DRAM_A),
      .DRAM_D     (DRAM_D),
      .DRAM_Q     (DRAM_Q),
      .DRAM_VALID (DRAM_VALID)
   );

   always #5 dram_clk = ~dram_clk;

   // kind: 0 = PRE, 1 = ACT, 2 = column command (RD/WR)
   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] wen;
      logic [31:0] d;
      bit          wr;
      int          gap;
   } cmd_t;

   typedef struct {
      bit          rd;
      logic [31:0] data;
   } rsp_t;

   cmd_t cmd_q[$];
   rsp_t rsp_q[$];
   logic [31:0] mem [int];

   int tests = 0;
   int fails = 0;
   int inject_cnt = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endfunction

   function automatic logic [31:0] rd_mem(int a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   task automatic exp_cmd(int kind, logic [31:0] a, logic [31:0] wen,
                          logic [31:0] d, bit wr, int gap);
      cmd_t e;
      e.kind = kind;
      e.a    = a;
      e.wen  = wen;
      e.d    = d;
      e.wr   = wr;
      e.gap  = gap;
      cmd_q.push_back(e);
   endtask

   task automatic exp_rsp(bit rd, logic [31:0] data);
      rsp_t r;
      r.rd   = rd;
      r.data = data;
      rsp_q.push_back(r);
   endtask

   task automatic issue(bit w, logic [20:0] a, logic [31:0] d,
                        logic [3:0] s, bit hold);
      int n;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_wstrb = s;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge dram_clk);
         n++;
      end
      if (!req_ready) begin
         tests++;
         fails++;
         $display("FAIL accept_timeout: got ready=0 expected ready=1 addr=0x%0h", a);
      end
      @(posedge dram_clk);
      @(negedge dram_clk);
      if (!hold) begin
         req_valid = 1'b0;
         req_write = 1'b0;
         req_addr  = '0;
         req_wdata = '0;
         req_wstrb = '0;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((rsp_q.size() != 0 || cmd_q.size() != 0) && n < 200) begin
         @(negedge dram_clk);
         n++;
      end
      chk("drain_in_time", 32'(n < 200), 32'd1);
      if (n >= 200) begin
         cmd_q.delete();
         rsp_q.delete();
      end
      repeat (3) @(negedge dram_clk);
   endtask

   task automatic chk_reset_outputs();
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_csn", 32'(DRAM_CSn), 32'd1);
      chk("rst_rasn", 32'(DRAM_RASn), 32'd1);
      chk("rst_casn", 32'(DRAM_CASn), 32'd1);
      chk("rst_wen", 32'(DRAM_WEn), 32'hF);
      chk("rst_a", 32'(DRAM_A), 32'd0);
      chk("rst_d", DRAM_D, 32'd0);
   endtask

   // monitor + DRAM pin model, all at negedge
   initial begin : monitor
      int cyc, last_cmd, wr_cyc, dv_cyc, pend, k, addr, inj_seen;
      bit prev_rsp, ready_next, rd_pend, rdy_bad;
      logic [10:0] mrow;
      logic [31:0] w;
      cmd_t e;
      rsp_t r;
      cyc = 0; last_cmd = 0; wr_cyc = 0; dv_cyc = 0; pend = 0;
      addr = 0; inj_seen = 0; mrow = '0; w = '0;
      prev_rsp = 0; ready_next = 0; rd_pend = 0; rdy_bad = 0;
      DRAM_VALID = 1'b0;
      DRAM_Q = '0;
      forever begin
         @(negedge dram_clk);
         cyc++;
         if (rsp_valid) begin
            chk("rsp_single_pulse", 32'(prev_rsp), 32'd0);
            if (rsp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_rsp: got rsp_valid=1 rdata=0x%0h expected none", rsp_rdata);
            end else begin
               r = rsp_q.pop_front();
               if (r.rd) begin
                  chk("rsp_rdata", rsp_rdata, r.data);
                  chk("rsp_after_valid", 32'(cyc - dv_cyc), 32'd1);
                  chk("ready_low_in_rd_w", 32'(rdy_bad), 32'd0);
               end else begin
                  chk("wr_rsp_latency", 32'(cyc - wr_cyc), 32'(TWR));
               end
            end
            rd_pend = 0;
            ready_next = 1;
         end else if (ready_next) begin
            chk("ready_after_rsp", 32'(req_ready), 32'd1);
            ready_next = 0;
         end
         prev_rsp = rsp_valid;

         DRAM_VALID = 1'b0;
         if (!dram_rst_n) begin
            pend = 0;
         end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               DRAM_VALID = 1'b1;
               DRAM_Q = rd_mem(addr);
               dv_cyc = cyc;
            end
         end
         if (inj_seen != inject_cnt) begin
            inj_seen = inject_cnt;
            DRAM_VALID = 1'b1;
            DRAM_Q = 32'h0BADF00D;
            dv_cyc = cyc;
         end

         if (dram_rst_n && !DRAM_CSn &&
             !(DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF)) begin
            k = 3;
            if (!DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'h0) k = 0;
            else if (!DRAM_RASn && DRAM_CASn && DRAM_WEn == 4'hF) k = 1;
            else if (DRAM_RASn && !DRAM_CASn) k = 2;
            if (cmd_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_cmd: got kind=%0d A=0x%0h expected none", k, DRAM_A);
            end else begin
               e = cmd_q.pop_front();
               chk("cmd_kind", 32'(k), 32'(e.kind));
               if (e.kind != 0) chk("cmd_addr", 32'(DRAM_A), e.a);
               if (e.kind == 2) chk("cmd_wen", 32'(DRAM_WEn), e.wen);
               if (e.kind == 2 && e.wr) chk("cmd_d", DRAM_D, e.d);
               if (e.gap >= 0) chk("cmd_gap", 32'(cyc - last_cmd - 1), 32'(e.gap));
               if (e.kind == 2 && e.wr) wr_cyc = cyc;
               if (e.kind == 2 && !e.wr) begin
                  rd_pend = 1;
                  rdy_bad = 0;
               end
            end
            last_cmd = cyc;
            if (k == 1) mrow = DRAM_A;
            if (k == 2) begin
               addr = 32'({mrow, DRAM_A[9:0]});
               if (DRAM_WEn == 4'hF) begin
                  pend = 3;
               end else begin
                  w = rd_mem(addr);
                  for (int b = 0; b < 4; b++)
                     if (!DRAM_WEn[b]) w[8*b +: 8] = DRAM_D[8*b +: 8];
                  mem[addr] = w;
               end
            end
         end
         if (rd_pend && req_ready) rdy_bad = 1;
      end
   end

   initial begin : stim
      req_valid  = 1'b0;
      req_write  = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      req_wstrb  = '0;
      dram_rst_n = 1'b0;
      mem[32'h000005] = 32'hDEADBEEF;
      mem[32'h000800] = 32'hCAFEF00D;
      mem[32'h000801] = 32'h11111111;
      mem[32'h000802] = 32'h22222222;
      mem[32'h000803] = 32'h33333333;
      mem[32'h000C07] = 32'hA5A50F0F;

      repeat (3) @(negedge dram_clk);
      chk_reset_outputs();
      dram_rst_n = 1'b1;
      repeat (2) @(negedge dram_clk);
      chk("csn_after_reset", 32'(DRAM_CSn), 32'd0);

      // closed row: ACT, 5 NOPs, RD
      exp_cmd(1, 32'h000, 32'hF, 32'h0, 0, -1);
      exp_cmd(2, 32'h005, 32'hF, 32'h0, 0, 5);
      exp_rsp(1, 32'hDEADBEEF);
      issue(0, 21'h000005, 32'h0, 4'h0, 0);
      wait_done();

      // conflict write, then hit read of same word
      exp_cmd(0, 32'h0, 32'h0, 32'h0, 0, -1);
      exp_cmd(1, 32'h001, 32'hF, 32'h0, 0, 5);
      exp_cmd(2, 32'h000, 32'hA, 32'h12345678, 1, 5);
      exp_rsp(0, 32'h0);
      issue(1, 21'h000400, 32'h12345678, 4'b0101, 0);
      wait_done();
      exp_cmd(2, 32'h000, 32'hF, 32'h0, 0, -1);
      exp_rsp(1, 32'h00340078);
      issue(0, 21'h000400, 32'h0, 4'h0, 0);
      wait_done();

      // row 1 hit, then row 2 conflict
      exp_cmd(2, 32'h001, 32'hF, 32'h0, 0, -1);
      exp_rsp(1, 32'h0);
      issue(0, 21'h000401, 32'h0, 4'h0, 0);
      wait_done();
      exp_cmd(0, 32'h0, 32'h0, 32'h0, 0, -1);
      exp_cmd(1, 32'h002, 32'hF, 32'h0, 0, 5);
      exp_cmd(2, 32'h000, 32'hF, 32'h0, 0, 5);
      exp_rsp(1, 32'hCAFEF00D);
      issue(0, 21'h000800, 32'h0, 4'h0, 0);
      wait_done();

      // four back-to-back hits with req_valid held
      exp_cmd(2, 32'h000, 32'hF, 32'h0, 0, -1);
      exp_cmd(2, 32'h001, 32'hF, 32'h0, 0, 5);
      exp_cmd(2, 32'h002, 32'hF, 32'h0, 0, 5);
      exp_cmd(2, 32'h003, 32'hF, 32'h0, 0, 5);
      exp_rsp(1, 32'hCAFEF00D);
      exp_rsp(1, 32'h11111111);
      exp_rsp(1, 32'h22222222);
      exp_rsp(1, 32'h33333333);
      issue(0, 21'h000800, 32'h0, 4'h0, 1);
      issue(0, 21'h000801, 32'h0, 4'h0, 1);
      issue(0, 21'h000802, 32'h0, 4'h0, 1);
      issue(0, 21'h000803, 32'h0, 4'h0, 0);
      wait_done();

      // zero strobes: WR with WEn=F, still retires, memory untouched
      exp_cmd(2, 32'h004, 32'hF, 32'hFFFFFFFF, 1, -1);
      exp_rsp(0, 32'h0);
      issue(1, 21'h000804, 32'hFFFFFFFF, 4'h0, 0);
      wait_done();
      exp_cmd(2, 32'h004, 32'hF, 32'h0, 0, -1);
      exp_rsp(1, 32'h0);
      issue(0, 21'h000804, 32'h0, 4'h0, 0);
      wait_done();

      // reset while in ACT_W
      exp_cmd(0, 32'h0, 32'h0, 32'h0, 0, -1);
      exp_cmd(1, 32'h003, 32'hF, 32'h0, 0, 5);
      issue(0, 21'h000C07, 32'h0, 4'h0, 0);
      repeat (8) @(negedge dram_clk);
      dram_rst_n = 1'b0;
      @(negedge dram_clk);
      chk_reset_outputs();
      chk("cmdq_after_abort", 32'(cmd_q.size()), 32'd0);
      @(negedge dram_clk);
      dram_rst_n = 1'b1;
      repeat (2) @(negedge dram_clk);
      exp_cmd(1, 32'h003, 32'hF, 32'h0, 0, -1);
      exp_cmd(2, 32'h007, 32'hF, 32'h0, 0, 5);
      exp_rsp(1, 32'hA5A50F0F);
      issue(0, 21'h000C07, 32'h0, 4'h0, 0);
      wait_done();

      // stray DRAM_VALID while idle
      inject_cnt++;
      repeat (4) begin
         @(negedge dram_clk);
         chk("idle_valid_no_rsp", 32'(rsp_valid), 32'd0);
         chk("idle_valid_ready", 32'(req_ready), 32'd1);
      end
      chk("idle_valid_rdata", rsp_rdata, 32'hA5A50F0F);
      exp_cmd(2, 32'h007, 32'hF, 32'h0, 0, -1);
      exp_rsp(1, 32'hA5A50F0F);
      issue(0, 21'h000C07, 32'h0, 4'h0, 0);
      wait_done();

      chk("final_cmdq_empty", 32'(cmd_q.size()), 32'd0);
      chk("final_rspq_empty", 32'(rsp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dram_ctrl.md
# dram_ctrl

Single-port DRAM command controller between the AXI DRAM slave wrapper and the off-chip DRAM pins (DRAM_CSn/RASn/CASn/WEn/A/D/Q/VALID) in the DRAM clock domain. It accepts one word read or write request at a time and splits the 21-bit word address into an 11-bit row and a 10-bit column. It keeps the row open across requests (open-page policy) and sequences PRECHARGE / ACTIVATE / READ / WRITE with programmable wait counts. Read data is returned only after the DRAM asserts VALID.

## Interface
- TRP, default 5: cycles of NOP after PRECHARGE.
- TRCD, default 5: cycles of NOP after ACTIVATE.
- TWR, default 5: cycles of NOP after a WRITE command before the next command.
- dram_clk  in  1  DRAM-domain clock. One clock only.
- dram_rst_n  in  1  Reset. Synchronous, active-low.
- req_valid  in  1  Request present.
- req_ready  out  1  Controller accepts a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  21  Word address: row = [20:10], col = [9:0].
- req_wdata  in  32  Write data.
- req_wstrb  in  4  Byte enables, active-high.
- rsp_valid  out  1  One-cycle pulse: read data valid, or write retired.
- rsp_rdata  out  32  Read data, held until the next rsp_valid.
- DRAM_CSn  out  1  Chip select, active-low.
- DRAM_RASn  out  1  Row strobe, active-low.
- DRAM_CASn  out  1  Column strobe, active-low.
- DRAM_WEn  out  4  Per-byte write enable, active-low.
- DRAM_A  out  11  Row address on ACT; {1'b0, col} on RD/WR.
- DRAM_D  out  32  Write data.
- DRAM_Q  in  32  Read data.
- DRAM_VALID  in  1  DRAM_Q is valid this cycle.

## Operation
- Command encodings (CSn=0 for all):
  - NOP: RASn=1, CASn=1, WEn=4'hF.
  - PRE: RASn=0, CASn=1, WEn=4'h0.
  - ACT: RASn=0, CASn=1, WEn=4'hF, A=row.
  - RD: RASn=1, CASn=0, WEn=4'hF.
  - WR: RASn=1, CASn=0, WEn=~wstrb, D=wdata.
- Each command lasts exactly one cycle. Every non-command cycle is NOP.
- State and register tracking:
  - open_row register plus row_open flag; row_open=0 after reset.
  - Request fields are latched at acceptance; pins are driven from the latch, not from req_* inputs.
- FSM states: IDLE, PRE, PRE_W, ACT, ACT_W, RD, RD_W, WR, WR_W.
- Transitions:
  - IDLE: req_ready=1. On req_valid, latch the request, then:
    - row hit (row_open && row==open_row) -> RD or WR.
    - row_open with a different row -> PRE.
    - !row_open -> ACT.
  - PRE -> PRE_W, which counts TRP cycles, clears row_open, then -> ACT.
  - ACT -> ACT_W, which counts TRCD cycles, sets row_open and open_row, then -> RD or WR.
  - RD -> RD_W. RD_W waits for DRAM_VALID with no timeout. On VALID: capture DRAM_Q into rsp_rdata, pulse rsp_valid, go to IDLE.
  - WR -> WR_W, which counts TWR cycles, pulses rsp_valid on the last count, then -> IDLE.
- Wait counter: 4 bits, loaded with param-1 on entry, transitions at 0. Parameters are limited to 1..15.
- At most one request is outstanding. req_ready=0 in every state except IDLE.
- req_wstrb=4'h0 still issues WR (WEn=4'hF) and still produces rsp_valid.
- The row stays open after RD/WR. There is no refresh and no auto-precharge.

## Timing
- Reset (dram_rst_n=0 at a dram_clk rising edge), next-cycle output values:
  - state=IDLE, row_open=0, counter=0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0.
  - CSn=1, RASn=1, CASn=1, WEn=4'hF, A=0, D=0.
- Reset mid-operation aborts immediately. The DRAM row state is then treated as closed.
- All outputs are registered.
- Latency from acceptance edge to the command on the pins:
  - Row-hit read: RD appears 1 cycle after acceptance. rsp_valid comes in the cycle after DRAM_VALID is sampled.
  - Miss, row closed: ACT at +1, RD/WR at +2+TRCD.
  - Conflict: PRE at +1, ACT at +2+TRP, RD/WR at +3+TRP+TRCD.
- Write rsp_valid is asserted in the TWR-th cycle after WR.
- req_ready returns to 1 in the cycle after rsp_valid. Back-to-back acceptance is therefore one request per rsp_valid+1.
- A DRAM_VALID outside RD_W is ignored.

## Test plan
- Reset, then a read of addr 0x000005 with the model returning 0xDEADBEEF 3 cycles after RD:
  - Pins show ACT A=0, 5 NOPs, then RD A=0x005.
  - rsp_rdata=0xDEADBEEF with a single rsp_valid pulse.
- Write 0x12345678 to 0x000400 with wstrb=4'b0101, then read the same address:
  - WR shows WEn=4'b1010, A=0x000.
  - The read is a row hit (no ACT) and returns 0x00340078 over a zeroed memory.
- Access row 1 (0x000400), then row 2 (0x000800):
  - Second access issues PRE, TRP NOPs, ACT A=0x002, TRCD NOPs, then RD.
- Hold req_valid high with 4 consecutive hit reads:
  - Exactly 4 RD commands, req_ready low during each RD_W, 4 rsp_valid pulses.
- Assert dram_rst_n=0 during ACT_W, then release:
  - All outputs take reset values.
  - The next read to the same row issues ACT again (row_open=0).
- Assert DRAM_VALID while IDLE -> no rsp_valid, no state change.
